// File: rtl/gpr_file_mp_if.sv
// gpr_file_mp_if: read, write and scoreboard bundle of the GPR file.
// master = decode/writeback side, slave = register file.
interface gpr_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int NUM_RD = 2
);
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr0_en;
    logic [ADDR_W-1:0]        wr0_addr;
    logic [DATA_W-1:0]        wr0_data;
    logic                     wr1_en;
    logic [ADDR_W-1:0]        wr1_addr;
    logic [DATA_W-1:0]        wr1_data;
    logic                     sb_set;
    logic [ADDR_W-1:0]        sb_addr;
    logic [DEPTH-1:0]         busy_vec;

    modport master (
        output rd_en, rd_addr,
        output wr0_en, wr0_addr, wr0_data,
        output wr1_en, wr1_addr, wr1_data,
        output sb_set, sb_addr,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_en, rd_addr,
        input  wr0_en, wr0_addr, wr0_data,
        input  wr1_en, wr1_addr, wr1_data,
        input  sb_set, sb_addr,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/gpr_file_mp.sv
// gpr_file_mp: multi-port GPR file, 2 write ports, registered reads, busy scoreboard.
// Optional macro GPR_FILE_BYPASS_EN: coincident reads return the write data.
module gpr_file_mp #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int NUM_RD = 2
) (
    input logic          clock,
    input logic          reset_n,
    gpr_file_mp_if.slave bus
);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic [DEPTH-1:0]  sb_s;
    logic [DEPTH-1:0]  sb_c;

    logic [ADDR_W-1:0] ra   [NUM_RD];
    logic [DATA_W-1:0] rval [NUM_RD];
    logic [NUM_RD-1:0] rbsy;
    logic [DATA_W-1:0] rdq  [NUM_RD];
    logic [NUM_RD-1:0] bsyq;

    // Scoreboard next state: writes clear, issue sets, set beats clear, r0 never busy.
    always_comb begin
        sb_s = '0;
        sb_c = '0;
        if (bus.sb_set) sb_s[bus.sb_addr] = 1'b1;
        if (bus.wr0_en) sb_c[bus.wr0_addr] = 1'b1;
        if (bus.wr1_en) sb_c[bus.wr1_addr] = 1'b1;
        busy_nxt = (busy & ~sb_c) | sb_s;
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) busy <= '0;
        else          busy <= busy_nxt;
    end

    // Register array: wr1 (load return) overrides wr0 on a shared address; r0 stays 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (bus.wr1_en && bus.wr1_addr == ADDR_W'(i))
                    regs[i] <= bus.wr1_data;
                else if (bus.wr0_en && bus.wr0_addr == ADDR_W'(i))
                    regs[i] <= bus.wr0_data;
            end
        end
    end

    // Read-port lookup, optionally forwarding a same-cycle write.
    always_comb begin
        rbsy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra[k]   = bus.rd_addr[k*ADDR_W +: ADDR_W];
            rval[k] = regs[ra[k]];
            rbsy[k] = busy[ra[k]];
`ifdef GPR_FILE_BYPASS_EN
            if (ra[k] != '0) begin
                if (bus.wr1_en && bus.wr1_addr == ra[k]) begin
                    rval[k] = bus.wr1_data;
                    rbsy[k] = busy_nxt[ra[k]];
                end else if (bus.wr0_en && bus.wr0_addr == ra[k]) begin
                    rval[k] = bus.wr0_data;
                    rbsy[k] = busy_nxt[ra[k]];
                end
            end
`endif
        end
    end

    // Read output registers: load on strobe, otherwise hold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_RD; k++) rdq[k] <= '0;
            bsyq <= '0;
        end else begin
            for (int k = 0; k < NUM_RD; k++) begin
                if (bus.rd_en[k]) begin
                    rdq[k]  <= rval[k];
                    bsyq[k] <= rbsy[k];
                end
            end
        end
    end

    // Flatten read outputs onto the bus.
    always_comb begin
        bus.rd_data = '0;
        for (int k = 0; k < NUM_RD; k++)
            bus.rd_data[k*DATA_W +: DATA_W] = rdq[k];
        bus.rd_busy  = bsyq;
        bus.busy_vec = busy;
    end

endmodule
